tdm_demux: RTL and testbench

- Receive end of a time-division-multiplexed link: the transmit side rotates a selector across N_CH sources and drives one word per beat.
- This block re-tracks the selector, steers each beat into its channel register, and presents a complete parallel frame with a one-cycle valid strobe.
- Sits downstream of the mux2_1 / mux datapath blocks and recovers the original d_0..d_(N_CH-1) values.

---
 rtl/tdm_demux_if.sv | 34 +++
 rtl/tdm_demux.sv | 132 +++++++++++++
 tb/tb_tdm_demux.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_if
// Description : Receive-side TDM bus: one multiplexed word per beat in,
//               recovered parallel frame and lock status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_demux_if #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
);
    logic [W-1:0]      din;
    logic              din_valid;
    logic              sync;
    logic [N_CH*W-1:0] dout;
    logic              frame_valid;
    logic [SEL_W-1:0]  sel;
    logic              locked;
    logic              sync_err;

    // Link side: drives beats, observes the recovered frame
    modport master (
        output din, din_valid, sync,
        input  dout, frame_valid, sel, locked, sync_err
    );

    // Demultiplexer side
    modport slave (
        input  din, din_valid, sync,
        output dout, frame_valid, sel, locked, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux
// Description : TDM receive demultiplexer. Re-tracks the transmit selector,
//               steers each beat into its channel slot and publishes a full
//               parallel frame with a one-cycle frame_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    tdm_demux_if.slave bus
);

    localparam logic [0:0]       c_HUNT     = 1'b0;
    localparam logic [0:0]       c_LOCKED   = 1'b1;
    localparam logic [SEL_W-1:0] c_FIRST    = '0;
    localparam logic [SEL_W-1:0] c_SECOND   = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_LAST_SEL = SEL_W'(N_CH - 1);

    logic [0:0]        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic              r_frame_valid;
    logic              r_sync_err;
    logic [N_CH*W-1:0] r_dout;

    logic [0:0]        w_state_nx;
    logic [SEL_W-1:0]  w_sel_nx;
    logic              w_frame_valid_nx;
    logic              w_sync_err_nx;
    logic              w_wr_en;
    logic [SEL_W-1:0]  w_wr_idx;
    logic              w_dout_load;
    logic [N_CH*W-1:0] w_frame;

    // Next-state decode: one decision per beat, pulses default low
    always_comb begin
        w_state_nx       = r_state;
        w_sel_nx         = r_sel;
        w_frame_valid_nx = 1'b0;
        w_sync_err_nx    = 1'b0;
        w_wr_en          = 1'b0;
        w_wr_idx         = r_sel;
        w_dout_load      = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                c_HUNT: begin
                    // Only a sync beat can start a frame while hunting
                    if (bus.sync) begin
                        w_wr_en    = 1'b1;
                        w_wr_idx   = c_FIRST;
                        w_sel_nx   = c_SECOND;
                        w_state_nx = c_LOCKED;
                    end
                end
                default: begin
                    if (bus.sync && (r_sel != c_FIRST)) begin
                        // Early sync: drop the partial frame, restart at channel 0
                        w_sync_err_nx = 1'b1;
                        w_wr_en       = 1'b1;
                        w_wr_idx      = c_FIRST;
                        w_sel_nx      = c_SECOND;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_sel == c_LAST_SEL) begin
                            w_dout_load      = 1'b1;
                            w_frame_valid_nx = 1'b1;
                            w_sel_nx         = c_FIRST;
                        end else begin
                            w_sel_nx = r_sel + SEL_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Control state and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_HUNT;
            r_sel         <= c_FIRST;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_sel         <= w_sel_nx;
            r_frame_valid <= w_frame_valid_nx;
            r_sync_err    <= w_sync_err_nx;
        end
    end

    // Channels 0..N_CH-2 are staged in shadow words; the last channel is
    // taken straight from din so the frame publishes on its own beat.
    for (genvar k = 0; k < N_CH - 1; k++) begin : g_shadow
        logic [W-1:0] r_word;

        // Capture this channel's beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_word <= '0;
            end else if (w_wr_en && (w_wr_idx == SEL_W'(k))) begin
                r_word <= bus.din;
            end
        end

        assign w_frame[k*W +: W] = r_word;
    end

    assign w_frame[(N_CH-1)*W +: W] = bus.din;

    // Published frame holds until the next complete frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_dout_load) begin
            r_dout <= w_frame;
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sel         = r_sel;
    assign bus.locked      = (r_state == c_LOCKED);
    assign bus.sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux
// Description : Self-checking bench for tdm_demux (4x4-bit and 2x1-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tdm_demux_if #(.N_CH(4), .W(4), .SEL_W(2)) bus4 ();
    tdm_demux_if #(.N_CH(2), .W(1), .SEL_W(1)) bus2 ();

    tdm_demux #(.N_CH(4), .W(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    tdm_demux #(.N_CH(2), .W(1), .SEL_W(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int checks   = 0;
    int failures = 0;

    // Reference model for the 4-channel instance: a partial-frame queue
    logic [3:0]  m_q[$];
    bit          m_locked;
    logic [15:0] m_dout;
    bit          m_fv;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_locked = 0;
        m_dout   = '0;
        m_fv     = 0;
        m_err    = 0;
    endtask

    task automatic model_beat(input bit v, input logic [3:0] d, input bit s);
        m_fv  = 0;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_q      = {d};
                    m_locked = 1;
                end
            end else if (s && m_q.size() != 0) begin
                m_err = 1;
                m_q   = {d};
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_dout = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_fv   = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".dout"},     32'(bus4.dout),        32'(m_dout));
        chk({tag, ".fv"},       32'(bus4.frame_valid), 32'(m_fv));
        chk({tag, ".sel"},      32'(bus4.sel),         32'(m_q.size()));
        chk({tag, ".locked"},   32'(bus4.locked),      32'(m_locked));
        chk({tag, ".sync_err"}, 32'(bus4.sync_err),    32'(m_err));
    endtask

    // One clock edge on both instances; outputs are stable 1 ns after it
    task automatic step(input bit v4, input logic [3:0] d4, input bit s4,
                        input bit v2, input logic d2, input bit s2);
        @(negedge clk);
        bus4.din_valid = v4; bus4.din = d4; bus4.sync = s4;
        bus2.din_valid = v2; bus2.din = d2; bus2.sync = s2;
        @(posedge clk);
        #1;
        model_beat(v4, d4, s4);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus4.din_valid = 0; bus2.din_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("rst.dout4",   32'(bus4.dout),        32'h0);
        chk("rst.fv4",     32'(bus4.frame_valid), 32'h0);
        chk("rst.sel4",    32'(bus4.sel),         32'h0);
        chk("rst.locked4", 32'(bus4.locked),      32'h0);
        chk("rst.err4",    32'(bus4.sync_err),    32'h0);
        chk("rst.dout2",   32'(bus2.dout),        32'h0);
        chk("rst.locked2", 32'(bus2.locked),      32'h0);
    endtask

    typedef struct {
        bit          rst_before;
        logic [3:0]  din;
        bit          v;
        bit          s;
        bit          e_fv;
        logic [15:0] e_dout;
        logic [1:0]  e_sel;
        bit          e_lk;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] d, bit v, bit s, bit fv,
                                logic [15:0] dout, logic [1:0] sl, bit lk, bit er);
        vec_t t;
        t.rst_before = r; t.din = d; t.v = v; t.s = s;
        t.e_fv = fv; t.e_dout = dout; t.e_sel = sl; t.e_lk = lk; t.e_err = er;
        return t;
    endfunction

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic d0_prev;
        bus4.din_valid = 0; bus4.din = '0; bus4.sync = 0;
        bus2.din_valid = 0; bus2.din = '0; bus2.sync = 0;
        model_reset();

        // Basic frame A,B,C,D
        vecs.push_back(mk(1, 4'hA, 1, 1, 0, 16'h0000, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'hB, 1, 0, 0, 16'h0000, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'hC, 1, 0, 0, 16'h0000, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'hD, 1, 0, 1, 16'hDCBA, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 16'hDCBA, 2'd0, 1, 0));
        // Unsynced beats are ignored while hunting
        vecs.push_back(mk(1, 4'h1, 1, 0, 0, 16'h0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'h2, 1, 0, 0, 16'h0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'h3, 1, 1, 0, 16'h0000, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'h4, 1, 0, 0, 16'h0000, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'h5, 1, 0, 0, 16'h0000, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'h6, 1, 0, 1, 16'h6543, 2'd0, 1, 0));
        // Early sync -> resync
        vecs.push_back(mk(0, 4'h1, 1, 1, 0, 16'h6543, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'h2, 1, 0, 0, 16'h6543, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'h5, 1, 1, 0, 16'h6543, 2'd1, 1, 1));
        vecs.push_back(mk(0, 4'h6, 1, 0, 0, 16'h6543, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'h7, 1, 0, 0, 16'h6543, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'h8, 1, 0, 1, 16'h8765, 2'd0, 1, 0));
        // Gaps mid-frame, then flywheel frames without sync
        vecs.push_back(mk(0, 4'h1, 1, 1, 0, 16'h8765, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'h2, 1, 0, 0, 16'h8765, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'hF, 0, 1, 0, 16'h8765, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'hE, 0, 0, 0, 16'h8765, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'hD, 0, 1, 0, 16'h8765, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'h3, 1, 0, 0, 16'h8765, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'h4, 1, 0, 1, 16'h4321, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'h5, 1, 0, 0, 16'h4321, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'h6, 1, 0, 0, 16'h4321, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'h7, 1, 0, 0, 16'h4321, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'h8, 1, 0, 1, 16'h8765, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'h9, 1, 0, 0, 16'h8765, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'hA, 1, 0, 0, 16'h8765, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'hB, 1, 0, 0, 16'h8765, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'hC, 1, 0, 1, 16'hCBA9, 2'd0, 1, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) apply_reset();
            step(vecs[i].v, vecs[i].din, vecs[i].s, 0, 1'b0, 0);
            chk($sformatf("vec%0d.dout", i),   32'(bus4.dout),        32'(vecs[i].e_dout));
            chk($sformatf("vec%0d.fv", i),     32'(bus4.frame_valid), 32'(vecs[i].e_fv));
            chk($sformatf("vec%0d.sel", i),    32'(bus4.sel),         32'(vecs[i].e_sel));
            chk($sformatf("vec%0d.locked", i), 32'(bus4.locked),      32'(vecs[i].e_lk));
            chk($sformatf("vec%0d.err", i),    32'(bus4.sync_err),    32'(vecs[i].e_err));
        end

        // Asynchronous reset mid-frame: outputs clear before the next edge
        step(1, 4'h1, 1, 0, 1'b0, 0);
        step(1, 4'h2, 0, 0, 1'b0, 0);
        #2;
        bus4.din_valid = 0;
        rst = 1;
        #1;
        chk("arst.dout",   32'(bus4.dout),   32'h0);
        chk("arst.locked", 32'(bus4.locked), 32'h0);
        chk("arst.sel",    32'(bus4.sel),    32'h0);
        #4;
        rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 4'(i + 3), 0, 0, 1'b0, 0);
            check_model($sformatf("nosync%0d", i));
        end

        // Randomized traffic against the queue model
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 4'($urandom), ($urandom % 6) == 0, 0, 1'b0, 0);
            check_model("rand");
        end

        // Two-channel serializer: d_0 toggles fastest, d_1 at half rate,
        // transmitter alternates between them every beat
        apply_reset();
        d0_prev = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic d0, d1;
            d0 = 1'((n >> 1) & 1);
            d1 = 1'((n >> 2) & 1);
            step(0, 4'h0, 0, 1, (n % 2) ? d1 : d0, n == 0);
            chk("n2.sel",    32'(bus2.sel),    32'((n + 1) % 2));
            chk("n2.locked", 32'(bus2.locked), 32'h1);
            if (n % 2) begin
                chk("n2.fv",   32'(bus2.frame_valid), 32'h1);
                chk("n2.dout", 32'(bus2.dout),        32'({d1, d0_prev}));
            end else begin
                chk("n2.fv", 32'(bus2.frame_valid), 32'h0);
                d0_prev = d0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
